// File: rtl/memory_to_ps2.sv
// memory_to_ps2: host-to-device PS/2 transmitter fed from a RAM mailbox.
// The CPU posts {request, byte} at CMD_ADDR. The block reads the mailbox over
// RAM Port B, clears the request bit, and sends the byte with the PS/2
// host-transmit protocol. It then writes a status word to STATUS_ADDR.
//
// Status word: {byte[7:0], 3'b000, retries[1:0], timeout, nack, done=1}
//
// Ports:
//   clk      in     system clock (50 MHz)
//   reset    in     synchronous, active-high reset
//   PS2_CLK  inout  open-drain PS/2 clock (driven 0 or released)
//   PS2_DAT  inout  open-drain PS/2 data  (driven 0 or released)
//   addr_b   out    RAM Port B address (registered)
//   data_b   out    RAM Port B write data (registered)
//   we_b     out    RAM Port B write enable, one cycle per write (registered)
//   q_b      in     RAM Port B read data, valid RD_LAT cycles after addr_b
//   tx_busy  out    high from request accept until the status write
//
// Optional build macro: PS2_TX_RETRY_EN. When defined, a NACK or timeout
// re-enters INHIBIT with the same byte up to two times, and the retry count
// is reported in status bits [4:3].
//
// state      | meaning
// -----------+------------------------------------------------------------
// POLL       | present CMD_ADDR on Port B
// RD_WAIT    | wait RD_LAT cycles for mailbox read data
// CHECK      | test request bit, latch byte and odd parity
// CLR        | write mailbox back with the request bit cleared
// INHIBIT    | hold PS2_CLK low; start bit asserted on the last cycle
// START      | release PS2_CLK, keep start bit, arm bit index and timeout
// SHIFT      | drive data, parity, stop on successive device falling edges
// ACK        | sample device ACK on the next falling edge
// IDLE_WAIT  | wait for both lines high
// STATUS     | write status word, drop tx_busy

module memory_to_ps2 #(
  parameter logic [15:0] CMD_ADDR       = 16'h00E1,
  parameter logic [15:0] STATUS_ADDR    = 16'h00E2,
  parameter int          RD_LAT         = 1,
  parameter int          INHIBIT_CYCLES = 5000,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire         PS2_CLK,
  inout  wire         PS2_DAT,
  output logic [15:0] addr_b,
  output logic [15:0] data_b,
  output logic        we_b,
  input  logic [15:0] q_b,
  output logic        tx_busy
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > RD_LAT) ? INHIBIT_CYCLES : RD_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_POLL, S_RD_WAIT, S_CHECK, S_CLR, S_INHIBIT,
    S_START, S_SHIFT, S_ACK, S_IDLE_WAIT, S_STATUS
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    byte_q, byte_d;
  logic          parity_q, parity_d;
  logic          nack_q, nack_d;
  logic          timeout_q, timeout_d;
  logic [1:0]    retry_q, retry_d;
  logic [15:0]   addr_b_q, addr_b_d;
  logic [15:0]   data_b_q, data_b_d;
  logic          we_b_q, we_b_d;
  logic          tx_busy_q, tx_busy_d;
  logic          clk_low_q, clk_low_d;
  logic          dat_low_q, dat_low_d;
  logic          clk_meta_q, clk_meta_d;
  logic          clk_sync_q, clk_sync_d;
  logic          clk_prev_q, clk_prev_d;
  logic          dat_meta_q, dat_meta_d;
  logic          dat_sync_q, dat_sync_d;

  logic fall;
  logic tmo_hit;
  logic fail_tmo;
  logic go_inhibit;

  // Only the request flag and the payload byte of the mailbox are meaningful.
  logic unused_q_bits;
  assign unused_q_bits = ^q_b[14:8];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    bit_idx_d  = bit_idx_q;
    byte_d     = byte_q;
    parity_d   = parity_q;
    nack_d     = nack_q;
    timeout_d  = timeout_q;
    retry_d    = retry_q;
    addr_b_d   = addr_b_q;
    data_b_d   = data_b_q;
    we_b_d     = 1'b0;
    tx_busy_d  = tx_busy_q;
    clk_low_d  = clk_low_q;
    dat_low_d  = dat_low_q;
    clk_meta_d = PS2_CLK;
    clk_sync_d = clk_meta_q;
    clk_prev_d = clk_sync_q;
    dat_meta_d = PS2_DAT;
    dat_sync_d = dat_meta_q;
    fall       = clk_prev_q & ~clk_sync_q;
    tmo_hit    = 1'b0;
    fail_tmo   = 1'b0;
    go_inhibit = 1'b0;

    // Down-counter reloaded by every device falling edge; terminal count
    // means the device went silent for TIMEOUT_CYCLES.
    if (state_q inside {S_SHIFT, S_ACK, S_IDLE_WAIT}) begin
      if (fall) begin
        tmo_d = TW'(TIMEOUT_CYCLES - 1);
      end else if (tmo_q != '0) begin
        tmo_d = tmo_q - TW'(1);
      end
      tmo_hit = !fall && (tmo_q == '0);
    end

    case (state_q)
      S_POLL: begin
        addr_b_d = CMD_ADDR;
        cnt_d    = CW'(RD_LAT - 1);
        state_d  = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_CHECK: begin
        if (!q_b[15]) begin
          state_d = S_POLL;
        end else begin
          byte_d    = q_b[7:0];
          parity_d  = ~^q_b[7:0];
          tx_busy_d = 1'b1;
          nack_d    = 1'b0;
          timeout_d = 1'b0;
          retry_d   = 2'd0;
          state_d   = S_CLR;
        end
      end
      S_CLR: begin
        addr_b_d   = CMD_ADDR;
        data_b_d   = {8'h00, byte_q};
        we_b_d     = 1'b1;
        go_inhibit = 1'b1;
      end
      S_INHIBIT: begin
        if (cnt_q == '0) begin
          clk_low_d = 1'b0;
          state_d   = S_START;
        end else begin
          cnt_d = cnt_q - CW'(1);
          // Start bit goes low together with the last inhibit cycle.
          if (cnt_q == CW'(1)) dat_low_d = 1'b1;
        end
      end
      S_START: begin
        bit_idx_d = 4'd0;
        tmo_d     = TW'(TIMEOUT_CYCLES - 1);
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (tmo_hit) begin
          fail_tmo = 1'b1;
        end else if (fall) begin
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q < 4'd8) begin
            dat_low_d = ~byte_q[bit_idx_q[2:0]];
          end else if (bit_idx_q == 4'd8) begin
            dat_low_d = ~parity_q;
          end else begin
            dat_low_d = 1'b0;
            state_d   = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (tmo_hit) begin
          fail_tmo = 1'b1;
        end else if (fall) begin
          nack_d  = dat_sync_q;
          state_d = S_IDLE_WAIT;
        end
      end
      S_IDLE_WAIT: begin
        if (clk_sync_q && dat_sync_q) begin
`ifdef PS2_TX_RETRY_EN
          if (nack_q && retry_q != 2'd2) begin
            retry_d    = retry_q + 2'd1;
            nack_d     = 1'b0;
            go_inhibit = 1'b1;
          end else begin
            state_d = S_STATUS;
          end
`else
          state_d = S_STATUS;
`endif
        end else if (tmo_hit) begin
          fail_tmo = 1'b1;
        end
      end
      S_STATUS: begin
        addr_b_d  = STATUS_ADDR;
        data_b_d  = {byte_q, 3'b000, retry_q, timeout_q, nack_q, 1'b1};
        we_b_d    = 1'b1;
        tx_busy_d = 1'b0;
        state_d   = S_POLL;
      end
      default: state_d = S_POLL;
    endcase

    if (fail_tmo) begin
      clk_low_d = 1'b0;
      dat_low_d = 1'b0;
      timeout_d = 1'b1;
      nack_d    = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_d    = retry_q + 2'd1;
        timeout_d  = 1'b0;
        go_inhibit = 1'b1;
      end else begin
        state_d = S_STATUS;
      end
`else
      state_d = S_STATUS;
`endif
    end

    if (go_inhibit) begin
      clk_low_d = 1'b1;
      dat_low_d = (INHIBIT_CYCLES == 1);
      cnt_d     = CW'(INHIBIT_CYCLES - 1);
      state_d   = S_INHIBIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_POLL;
      cnt_q      <= '0;
      tmo_q      <= '0;
      bit_idx_q  <= '0;
      byte_q     <= '0;
      parity_q   <= 1'b0;
      nack_q     <= 1'b0;
      timeout_q  <= 1'b0;
      retry_q    <= '0;
      addr_b_q   <= CMD_ADDR;
      data_b_q   <= '0;
      we_b_q     <= 1'b0;
      tx_busy_q  <= 1'b0;
      clk_low_q  <= 1'b0;
      dat_low_q  <= 1'b0;
      // Synchronisers start at the idle-high line level so reset never
      // produces a phantom falling edge.
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      bit_idx_q  <= bit_idx_d;
      byte_q     <= byte_d;
      parity_q   <= parity_d;
      nack_q     <= nack_d;
      timeout_q  <= timeout_d;
      retry_q    <= retry_d;
      addr_b_q   <= addr_b_d;
      data_b_q   <= data_b_d;
      we_b_q     <= we_b_d;
      tx_busy_q  <= tx_busy_d;
      clk_low_q  <= clk_low_d;
      dat_low_q  <= dat_low_d;
      clk_meta_q <= clk_meta_d;
      clk_sync_q <= clk_sync_d;
      clk_prev_q <= clk_prev_d;
      dat_meta_q <= dat_meta_d;
      dat_sync_q <= dat_sync_d;
    end
  end

  assign PS2_CLK = clk_low_q ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low_q ? 1'b0 : 1'bz;
  assign addr_b  = addr_b_q;
  assign data_b  = data_b_q;
  assign we_b    = we_b_q;
  assign tx_busy = tx_busy_q;

endmodule

// File: tb/tb_memory_to_ps2.sv
// Bench for memory_to_ps2: RAM model on Port B, a PS/2 device model on the
// open-drain lines, and a scoreboard of expected Port B writes.
module tb_memory_to_ps2;

  localparam logic [15:0] CMD_ADDR    = 16'h00E1;
  localparam logic [15:0] STATUS_ADDR = 16'h00E2;
  localparam int INH  = 60;
  localparam int TMO  = 300;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  wire  ps2_clk;
  wire  ps2_dat;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;

  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
  pullup (ps2_clk);
  pullup (ps2_dat);

  logic [15:0] addr_b;
  logic [15:0] data_b;
  logic [15:0] q_b = 16'h0000;
  logic        we_b;
  logic        tx_busy;

  logic [15:0] mbox = 16'h0000;
  logic [15:0] status_word = 16'h0000;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_wdata = 16'h0000;

  int n_cmp = 0;
  int n_err = 0;
  int bad;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  memory_to_ps2 #(
    .CMD_ADDR(CMD_ADDR), .STATUS_ADDR(STATUS_ADDR), .RD_LAT(1),
    .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
    .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b), .tx_busy(tx_busy)
  );

  // Single-port RAM with one-cycle read latency; CPU writes take priority.
  always @(posedge clk) begin
    q_b <= (addr_b == CMD_ADDR) ? mbox : (addr_b == STATUS_ADDR) ? status_word : 16'h0000;
    if (cpu_we) mbox <= cpu_wdata;
    else if (we_b && addr_b == CMD_ADDR) mbox <= data_b;
    if (we_b && addr_b == STATUS_ADDR) status_word <= data_b;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && we_b) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_write", {addr_b, data_b}, 32'h0);
      end else begin
        check_val("write", {addr_b, data_b}, exp_q.pop_front());
        if (addr_b == STATUS_ADDR) check_val("busy_at_status", {31'd0, tx_busy}, 32'd0);
        else                       check_val("busy_at_clr", {31'd0, tx_busy}, 32'd1);
      end
    end
  end

  task automatic cpu_request(input logic [15:0] w);
    exp_q.push_back({CMD_ADDR, 8'h00, w[7:0]});
    @(negedge clk);
    cpu_we = 1'b1;
    cpu_wdata = w;
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  // Device side of one host-to-device transfer. edges < 11 stops clocking
  // after that many falling edges; abort pulses reset after edge 5.
  task automatic dev_xfer(input logic [7:0] b, input int edges, input bit ack,
                          input bit abort, input bit push_st);
    int n;
    int nrx;
    bit seen_low;
    logic [9:0] rx;
    logic [9:0] mask;
    logic [9:0] frame;
    rx = '0;
    nrx = 0;
    if (push_st && !abort) begin
      if (edges < 11) exp_q.push_back({STATUS_ADDR, b, 8'h05});
      else            exp_q.push_back({STATUS_ADDR, b, 5'b0, 1'b0, ~ack, 1'b1});
    end
    n = 0;
    while (ps2_clk !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    check_val("inhibit_start", {31'd0, ps2_clk}, 32'd0);
    n = 0;
    while (ps2_clk === 1'b0 && n < 4 * INH) begin @(negedge clk); n++; end
    check_val("inhibit_len", n, INH);
    check_val("start_bit", {31'd0, ps2_dat}, 32'd0);
    check_val("busy_in_xfer", {31'd0, tx_busy}, 32'd1);
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= edges; k++) begin
      dev_clk_low = 1'b1;
      if (k == edges && edges < 11) begin
        // Count clk edges from the final device edge until DAT is let go.
        n = 0;
        seen_low = 1'b0;
        while (n < 2 * TMO) begin
          @(posedge clk);
          n++;
          @(negedge clk);
          if (n == HALF) dev_clk_low = 1'b0;
          if (ps2_dat === 1'b0) seen_low = 1'b1;
          else if (seen_low) break;
        end
        // Two synchroniser stages plus the edge-detect register.
        check_val("tmo_release", n, TMO + 3);
        check_val("tmo_clk_free", {31'd0, ps2_clk}, 32'd1);
        break;
      end
      repeat (HALF) @(negedge clk);
      if (k <= 10) begin
        rx[k-1] = ps2_dat;
        nrx = k;
      end
      dev_clk_low = 1'b0;
      if (abort && k == 5) begin
        repeat (4) @(negedge clk);
        check_val("pre_reset_dat", {31'd0, ps2_dat}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("rst_dat_free", {31'd0, ps2_dat}, 32'd1);
        check_val("rst_clk_free", {31'd0, ps2_clk}, 32'd1);
        check_val("rst_we", {31'd0, we_b}, 32'd0);
        check_val("rst_busy", {31'd0, tx_busy}, 32'd0);
        break;
      end
      if (k == 10 && ack) dev_dat_low = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    dev_dat_low = 1'b0;
    mask = 10'((32'd1 << nrx) - 32'd1);
    frame = {1'b1, ~^b, b};
    check_val("frame_bits", {22'd0, rx & mask}, {22'd0, frame & mask});
  endtask

  task automatic wait_writes(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    check_val(tag, exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_addr", {16'd0, addr_b}, {16'd0, CMD_ADDR});
    check_val("rst_data", {16'd0, data_b}, 32'd0);
    check_val("rst_we0", {31'd0, we_b}, 32'd0);
    check_val("rst_busy0", {31'd0, tx_busy}, 32'd0);
    check_val("rst_lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
    reset = 1'b0;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (we_b || tx_busy || ps2_clk !== 1'b1 || ps2_dat !== 1'b1) bad++;
    end
    check_val("idle_quiet", bad, 0);

    cpu_request(16'h80ED);
    dev_xfer(8'hED, 11, 1'b1, 1'b0, 1'b1);
    wait_writes("ack_status");
    check_val("status_ED", {16'd0, status_word}, 32'h0000ED01);

`ifndef PS2_TX_RETRY_EN
    cpu_request(16'h80FF);
    dev_xfer(8'hFF, 11, 1'b0, 1'b0, 1'b1);
    wait_writes("nack_status");

    cpu_request(16'h8055);
    dev_xfer(8'h55, 4, 1'b1, 1'b0, 1'b1);
    wait_writes("tmo_status");
    check_val("status_55", {16'd0, status_word}, 32'h00005505);
`endif

    cpu_request(16'h80ED);
    dev_xfer(8'hED, 11, 1'b1, 1'b1, 1'b1);
    repeat (200) @(negedge clk);
    check_val("no_status_after_rst", exp_q.size(), 0);
    cpu_request(16'h80F4);
    dev_xfer(8'hF4, 11, 1'b1, 1'b0, 1'b1);
    wait_writes("f4_status");
    check_val("mbox_cleared", {16'd0, mbox}, 32'h000000F4);
    check_val("status_F4", {16'd0, status_word}, 32'h0000F401);

`ifdef PS2_TX_RETRY_EN
    cpu_request(16'h80ED);
    exp_q.push_back({STATUS_ADDR, 16'hED09});
    dev_xfer(8'hED, 11, 1'b0, 1'b0, 1'b0);
    dev_xfer(8'hED, 11, 1'b1, 1'b0, 1'b0);
    wait_writes("retry_status");
`endif

    repeat (20) @(negedge clk);
    check_val("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
